// File: rtl/bit_stuffer.sv
// Bit stuffer: inserts a 0 after every MAX_ONES consecutive 1s of a tagged serial stream.
// Latency: 1 cycle, registered outputs; stuff bits occupy their own output cycle.
// Backpressure: bstr_stall holds the serializer for the stuff cycle; downstream never stalls.
module bit_stuffer #(
    parameter int MAX_ONES = 6,
    parameter int STUFF_W  = 6
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               bstr_in,
    input  logic [1:0]         bstr_in_ready,
    output logic               bstr_stall,
    output logic               bstr_out,
    output logic [1:0]         bstr_out_ready,
    output logic [STUFF_W-1:0] stuffed_out
);

    localparam int                 CNT_W      = $clog2(MAX_ONES + 1);
    localparam logic [CNT_W-1:0]   ONES_LIMIT = CNT_W'(MAX_ONES);
    localparam logic [STUFF_W-1:0] STUFF_MAX  = '1;
    localparam logic [1:0]         TAG_IDLE   = 2'b00;

    // ST_STUFF is the stuff_pending state: the next output cycle is a stuff 0.
    typedef enum logic {
        ST_PASS  = 1'b0,
        ST_STUFF = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   ones_q, ones_d;
    logic [1:0]         held_q, held_d;
    logic               out_d;
    logic [1:0]         tag_d;
    logic [STUFF_W-1:0] stuffed_d;

    // Per-packet bases: a tag change restarts both counters for the new bit.
    logic               new_pkt;
    logic [CNT_W-1:0]   ones_base;
    logic [CNT_W-1:0]   ones_inc;
    logic [STUFF_W-1:0] stuffed_base;
    logic [STUFF_W-1:0] stuffed_sat_inc;

    // Stall comes straight from the state register so there is no input-to-stall path.
    assign bstr_stall = (state_q == ST_STUFF);

    // Saturating increment of the stuffed-bit count; it must never wrap back to 0.
    assign stuffed_sat_inc = (stuffed_out == STUFF_MAX) ? STUFF_MAX
                                                        : stuffed_out + STUFF_W'(1);

    // Packet boundary detection and the counters a consumed bit builds on.
    always_comb begin
        new_pkt      = (bstr_in_ready != bstr_out_ready);
        ones_base    = new_pkt ? '0 : ones_q;
        stuffed_base = new_pkt ? '0 : stuffed_out;
        ones_inc     = ones_base + CNT_W'(1);
    end

    // Next-state and next-output logic; defaults describe an idle output cycle.
    always_comb begin
        state_d   = state_q;
        ones_d    = '0;
        held_d    = held_q;
        out_d     = 1'b1;
        tag_d     = TAG_IDLE;
        stuffed_d = '0;

        case (state_q)
            ST_STUFF: begin
                // Emit the stuff 0 under the tag of the bit that completed the run,
                // even if the serializer has already gone idle.
                out_d     = 1'b0;
                tag_d     = held_q;
                stuffed_d = stuffed_sat_inc;
                ones_d    = '0;
                state_d   = ST_PASS;
            end
            default: begin
                if (bstr_in_ready != TAG_IDLE) begin
                    out_d     = bstr_in;
                    tag_d     = bstr_in_ready;
                    stuffed_d = stuffed_base;
                    if (bstr_in) begin
                        ones_d = ones_inc;
                        if (ones_inc == ONES_LIMIT) begin
                            state_d = ST_STUFF;
                            held_d  = bstr_in_ready;
                        end
                    end else begin
                        ones_d = '0;
                    end
                end
            end
        endcase
    end

    // State and output registers; reset abandons any pending stuff bit.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q        <= ST_PASS;
            ones_q         <= '0;
            held_q         <= TAG_IDLE;
            bstr_out       <= 1'b1;
            bstr_out_ready <= TAG_IDLE;
            stuffed_out    <= '0;
        end else begin
            state_q        <= state_d;
            ones_q         <= ones_d;
            held_q         <= held_d;
            bstr_out       <= out_d;
            bstr_out_ready <= tag_d;
            stuffed_out    <= stuffed_d;
        end
    end

endmodule

// File: tb/tb_bit_stuffer.sv
// Bench for bit_stuffer: serializer driver honouring stall, stream-level reference model.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// Each scenario task compares every output cycle against the model inline.
module tb_bit_stuffer;

    localparam int MAX_ONES = 6;
    localparam int STUFF_W  = 6;
    localparam int SAT      = (1 << STUFF_W) - 1;

    logic               clk = 1'b0;
    logic               rst_b;
    logic               bstr_in;
    logic [1:0]         bstr_in_ready;
    logic               bstr_stall;
    logic               bstr_out;
    logic [1:0]         bstr_out_ready;
    logic [STUFF_W-1:0] stuffed_out;

    int checks = 0;
    int passed = 0;

    // Serializer items: tag 00 means an idle cycle.
    bit         it_bit[$];
    logic [1:0] it_tag[$];
    // Expected output stream.
    bit         e_bit[$];
    logic [1:0] e_tag[$];
    int         e_cnt[$];
    bit         e_stf[$];
    // Observed output stream.
    logic               o_bit[$];
    logic [1:0]         o_tag[$];
    logic [STUFF_W-1:0] o_cnt[$];
    logic               o_stall[$];
    int                 leftover;

    always #5 clk = ~clk;

    bit_stuffer #(.MAX_ONES(MAX_ONES), .STUFF_W(STUFF_W)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .bstr_in        (bstr_in),
        .bstr_in_ready  (bstr_in_ready),
        .bstr_stall     (bstr_stall),
        .bstr_out       (bstr_out),
        .bstr_out_ready (bstr_out_ready),
        .stuffed_out    (stuffed_out)
    );

    task automatic clear_items();
        it_bit.delete();
        it_tag.delete();
    endtask

    task automatic push_bit(input bit b, input logic [1:0] t);
        it_bit.push_back(b);
        it_tag.push_back(t);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push_bit(1'b1, 2'b00);
    endtask

    function automatic void push_exp(input bit b, input logic [1:0] t, input int c, input bit s);
        e_bit.push_back(b);
        e_tag.push_back(t);
        e_cnt.push_back(c);
        e_stf.push_back(s);
    endfunction

    // Stream-level model: each packet (run of one nonzero tag) gets a 0 after every
    // MAX_ONES ones; the stuff slot swallows an idle cycle that follows it, otherwise
    // it delays the next bit. Idle output resets the packet.
    function automatic void build_model();
        int         run;
        int         nst;
        logic [1:0] prev;
        e_bit.delete(); e_tag.delete(); e_cnt.delete(); e_stf.delete();
        run = 0; nst = 0; prev = 2'b00;
        for (int i = 0; i < it_bit.size(); i++) begin
            if (it_tag[i] == 2'b00) begin
                push_exp(1'b1, 2'b00, 0, 1'b0);
                prev = 2'b00; run = 0; nst = 0;
            end else begin
                if (it_tag[i] != prev) begin run = 0; nst = 0; end
                prev = it_tag[i];
                push_exp(it_bit[i], it_tag[i], nst, 1'b0);
                run = it_bit[i] ? run + 1 : 0;
                if (run == MAX_ONES) begin
                    nst = (nst < SAT) ? nst + 1 : SAT;
                    push_exp(1'b0, it_tag[i], nst, 1'b1);
                    run = 0;
                    if (i + 1 < it_bit.size() && it_tag[i+1] == 2'b00) i++;
                end
            end
        end
    endfunction

    // Acts as the serializer for as many cycles as the model predicts output cycles.
    task automatic run_items();
        int   idx;
        logic sp;
        o_bit.delete(); o_tag.delete(); o_cnt.delete(); o_stall.delete();
        idx = 0;
        for (int c = 0; c < e_bit.size(); c++) begin
            if (idx < it_bit.size()) begin
                bstr_in       = it_bit[idx];
                bstr_in_ready = it_tag[idx];
            end else begin
                bstr_in       = 1'b0;
                bstr_in_ready = 2'b00;
            end
            sp = bstr_stall;
            @(posedge clk);
            if (idx < it_bit.size() && (it_tag[idx] == 2'b00 || !sp)) idx++;
            @(negedge clk);
            o_bit.push_back(bstr_out);
            o_tag.push_back(bstr_out_ready);
            o_cnt.push_back(stuffed_out);
            o_stall.push_back(bstr_stall);
        end
        bstr_in       = 1'b0;
        bstr_in_ready = 2'b00;
        leftover      = it_bit.size() - idx;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; bstr_in = 1'b0; bstr_in_ready = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bstr_out !== 1'b1 || bstr_out_ready !== 2'b00 || stuffed_out !== '0 || bstr_stall !== 1'b0)
            $display("FAIL reset_state got out=%b tag=%b cnt=%0d stall=%b want 1 00 0 0",
                     bstr_out, bstr_out_ready, stuffed_out, bstr_stall);
        else passed++;
        rst_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bstr_out !== 1'b1 || bstr_out_ready !== 2'b00 || stuffed_out !== '0)
            $display("FAIL reset_release_idle got out=%b tag=%b cnt=%0d want 1 00 0",
                     bstr_out, bstr_out_ready, stuffed_out);
        else passed++;
    endtask

    task automatic test_token_stuff();
        bit pat[9] = '{1, 1, 1, 1, 1, 1, 0, 1, 0};
        int nstall;
        clear_items();
        for (int i = 0; i < 7; i++) push_bit(1'b1, 2'b01);
        push_bit(1'b0, 2'b01);
        push_idle(2);
        build_model();
        run_items();
        for (int k = 0; k < e_bit.size(); k++) begin
            logic es;
            es = (k + 1 < e_stf.size()) ? e_stf[k+1] : 1'b0;
            checks++;
            if (o_bit[k] !== e_bit[k] || o_tag[k] !== e_tag[k] || o_cnt[k] !== STUFF_W'(e_cnt[k]) || o_stall[k] !== es)
                $display("FAIL token k=%0d got bit=%b tag=%b cnt=%0d stall=%b want %b %b %0d %b",
                         k, o_bit[k], o_tag[k], o_cnt[k], o_stall[k], e_bit[k], e_tag[k], e_cnt[k], es);
            else passed++;
        end
        nstall = 0;
        for (int k = 0; k < 9; k++) begin
            if (o_stall[k] === 1'b1) nstall++;
            checks++;
            if (o_bit[k] !== pat[k] || o_tag[k] !== 2'b01)
                $display("FAIL token_pattern k=%0d got bit=%b tag=%b want %b 01", k, o_bit[k], o_tag[k], pat[k]);
            else passed++;
        end
        checks++;
        if (nstall != 1 || o_stall[5] !== 1'b1 || o_cnt[6] !== 6'd1 || o_cnt[8] !== 6'd1)
            $display("FAIL token_stall got stalls=%0d stall5=%b cnt6=%0d cnt8=%0d want 1 1 1 1",
                     nstall, o_stall[5], o_cnt[6], o_cnt[8]);
        else passed++;
        checks++;
        if (leftover != 0) $display("FAIL token_consumed got left=%0d want 0", leftover);
        else passed++;
    endtask

    task automatic test_alternating();
        int nstall;
        clear_items();
        for (int i = 0; i < 16; i++) push_bit(i[0] ? 1'b0 : 1'b1, 2'b10);
        push_idle(2);
        build_model();
        run_items();
        nstall = 0;
        for (int k = 0; k < e_bit.size(); k++) begin
            logic es;
            es = (k + 1 < e_stf.size()) ? e_stf[k+1] : 1'b0;
            if (o_stall[k] !== 1'b0) nstall++;
            checks++;
            if (o_bit[k] !== e_bit[k] || o_tag[k] !== e_tag[k] || o_cnt[k] !== STUFF_W'(e_cnt[k]) || o_stall[k] !== es)
                $display("FAIL alternating k=%0d got bit=%b tag=%b cnt=%0d stall=%b want %b %b %0d %b",
                         k, o_bit[k], o_tag[k], o_cnt[k], o_stall[k], e_bit[k], e_tag[k], e_cnt[k], es);
            else passed++;
        end
        checks++;
        if (nstall != 0 || e_bit.size() != 18) $display("FAIL alternating_nostall got stalls=%0d len=%0d want 0 18", nstall, e_bit.size());
        else passed++;
    endtask

    task automatic test_final_stuff();
        bit pre[4] = '{0, 1, 0, 0};
        clear_items();
        for (int i = 0; i < 4; i++) push_bit(pre[i], 2'b11);
        for (int i = 0; i < 6; i++) push_bit(1'b1, 2'b11);
        push_idle(2);
        build_model();
        run_items();
        for (int k = 0; k < e_bit.size(); k++) begin
            logic es;
            es = (k + 1 < e_stf.size()) ? e_stf[k+1] : 1'b0;
            checks++;
            if (o_bit[k] !== e_bit[k] || o_tag[k] !== e_tag[k] || o_cnt[k] !== STUFF_W'(e_cnt[k]) || o_stall[k] !== es)
                $display("FAIL final_stuff k=%0d got bit=%b tag=%b cnt=%0d stall=%b want %b %b %0d %b",
                         k, o_bit[k], o_tag[k], o_cnt[k], o_stall[k], e_bit[k], e_tag[k], e_cnt[k], es);
            else passed++;
        end
        checks++;
        if (o_bit[10] !== 1'b0 || o_tag[10] !== 2'b11 || o_cnt[10] !== 6'd1 ||
            o_bit[11] !== 1'b1 || o_tag[11] !== 2'b00 || o_cnt[11] !== 6'd0)
            $display("FAIL final_stuff_tail got %b/%b/%0d then %b/%b/%0d want 0/11/1 then 1/00/0",
                     o_bit[10], o_tag[10], o_cnt[10], o_bit[11], o_tag[11], o_cnt[11]);
        else passed++;
    endtask

    task automatic test_twelve_ones();
        clear_items();
        for (int i = 0; i < 12; i++) push_bit(1'b1, 2'b10);
        push_idle(2);
        build_model();
        run_items();
        for (int k = 0; k < e_bit.size(); k++) begin
            logic es;
            es = (k + 1 < e_stf.size()) ? e_stf[k+1] : 1'b0;
            checks++;
            if (o_bit[k] !== e_bit[k] || o_tag[k] !== e_tag[k] || o_cnt[k] !== STUFF_W'(e_cnt[k]) || o_stall[k] !== es)
                $display("FAIL twelve_ones k=%0d got bit=%b tag=%b cnt=%0d stall=%b want %b %b %0d %b",
                         k, o_bit[k], o_tag[k], o_cnt[k], o_stall[k], e_bit[k], e_tag[k], e_cnt[k], es);
            else passed++;
        end
        checks++;
        if (o_bit[6] !== 1'b0 || o_bit[13] !== 1'b0 || o_cnt[13] !== 6'd2)
            $display("FAIL twelve_ones_count got bit6=%b bit13=%b cnt13=%0d want 0 0 2", o_bit[6], o_bit[13], o_cnt[13]);
        else passed++;
    endtask

    task automatic test_saturate();
        int nstall;
        int maxc;
        clear_items();
        for (int i = 0; i < 450; i++) push_bit(1'b1, 2'b10);
        push_idle(2);
        build_model();
        run_items();
        nstall = 0; maxc = 0;
        for (int k = 0; k < e_bit.size(); k++) begin
            logic es;
            es = (k + 1 < e_stf.size()) ? e_stf[k+1] : 1'b0;
            if (o_stall[k] === 1'b1) nstall++;
            if (int'(o_cnt[k]) > maxc) maxc = int'(o_cnt[k]);
            checks++;
            if (o_bit[k] !== e_bit[k] || o_tag[k] !== e_tag[k] || o_cnt[k] !== STUFF_W'(e_cnt[k]) || o_stall[k] !== es)
                $display("FAIL saturate k=%0d got bit=%b tag=%b cnt=%0d stall=%b want %b %b %0d %b",
                         k, o_bit[k], o_tag[k], o_cnt[k], o_stall[k], e_bit[k], e_tag[k], e_cnt[k], es);
            else passed++;
        end
        checks++;
        if (nstall != 75 || maxc != 63 || o_cnt[524] !== 6'd63)
            $display("FAIL saturate_summary got stuffs=%0d max=%0d last=%0d want 75 63 63", nstall, maxc, o_cnt[524]);
        else passed++;
    endtask

    task automatic test_random();
        clear_items();
        for (int p = 0; p < 8; p++) begin
            logic [1:0] t;
            int len;
            t   = 2'($urandom_range(1, 3));
            len = $urandom_range(4, 40);
            for (int i = 0; i < len; i++) push_bit(($urandom_range(0, 3) != 0), t);
            push_idle($urandom_range(0, 3));
        end
        push_idle(2);
        build_model();
        run_items();
        for (int k = 0; k < e_bit.size(); k++) begin
            logic es;
            es = (k + 1 < e_stf.size()) ? e_stf[k+1] : 1'b0;
            checks++;
            if (o_bit[k] !== e_bit[k] || o_tag[k] !== e_tag[k] || o_cnt[k] !== STUFF_W'(e_cnt[k]) || o_stall[k] !== es)
                $display("FAIL random k=%0d got bit=%b tag=%b cnt=%0d stall=%b want %b %b %0d %b",
                         k, o_bit[k], o_tag[k], o_cnt[k], o_stall[k], e_bit[k], e_tag[k], e_cnt[k], es);
            else passed++;
        end
        checks++;
        if (leftover != 0) $display("FAIL random_consumed got left=%0d want 0", leftover);
        else passed++;
    endtask

    task automatic test_reset_pending();
        bstr_in = 1'b1; bstr_in_ready = 2'b10;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (bstr_stall !== 1'b1 || bstr_out !== 1'b1 || bstr_out_ready !== 2'b10 || stuffed_out !== '0)
            $display("FAIL rst_pending_setup got stall=%b out=%b tag=%b cnt=%0d want 1 1 10 0",
                     bstr_stall, bstr_out, bstr_out_ready, stuffed_out);
        else passed++;
        rst_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bstr_out !== 1'b1 || bstr_out_ready !== 2'b00 || stuffed_out !== '0 || bstr_stall !== 1'b0)
            $display("FAIL rst_pending_clear got out=%b tag=%b cnt=%0d stall=%b want 1 00 0 0",
                     bstr_out, bstr_out_ready, stuffed_out, bstr_stall);
        else passed++;
        rst_b = 1'b1; bstr_in = 1'b0; bstr_in_ready = 2'b00;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bstr_out !== 1'b1 || bstr_out_ready !== 2'b00 || stuffed_out !== '0 || bstr_stall !== 1'b0)
            $display("FAIL rst_pending_nostuff got out=%b tag=%b cnt=%0d stall=%b want 1 00 0 0",
                     bstr_out, bstr_out_ready, stuffed_out, bstr_stall);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_token_stuff();
        test_alternating();
        test_final_stuff();
        test_twelve_ones();
        test_saturate();
        test_random();
        test_reset_pending();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
